// File: rtl/des_pkg.sv
// DES constants and helpers shared by the round engine and its f-function.
// Holds the FSM state type, the round/subkey sizes, the IP/FP/E/P permutation
// tables (DES bit numbering, bit 1 = MSB), the eight S-boxes and the subkey
// index helper used to run the key schedule forwards or backwards.
package des_pkg;

  localparam int unsigned ROUNDS   = 16;
  localparam int unsigned SUBKEY_W = 48;

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  localparam int unsigned IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int unsigned FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int unsigned E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int unsigned P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each row packs 16 four-bit entries; column 0 is the most significant nibble.
  localparam logic [63:0] SBOX [8][4] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
      64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
      64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
      64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
      64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
      64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
      64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
      64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
      64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

  // Decryption walks the schedule backwards: 15 - cnt is the bitwise inverse.
  function automatic logic [3:0] subkey_index(input logic [3:0] cnt, input logic dec);
    return dec ? ~cnt : cnt;
  endfunction

  // Outer bits of the 6-bit group pick the row, inner four pick the column.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] six);
    logic [63:0] row;
    row = SBOX[box][{six[5], six[0]}];
    return 4'(row >> (6'd60 - {six[4:1], 2'b00}));
  endfunction

endpackage

// File: rtl/des_f_function.sv
// DES round function f(R, K) = P(S(E(R) ^ K)). Purely combinational.
// Ports:
//   r  in  32  right half of the current round state
//   k  in  48  round subkey
//   f  out 32  f-function result, XORed into the left half by the caller
module des_f_function (
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f
);
  import des_pkg::*;

  logic [47:0] e_out;
  logic [47:0] x;
  logic [31:0] s_out;

  for (genvar i = 0; i < 48; i++) begin : g_expand
    assign e_out[47 - i] = r[32 - E_TAB[i]];
  end

  assign x = e_out ^ k;

  for (genvar b = 0; b < 8; b++) begin : g_sbox
    assign s_out[31 - 4*b -: 4] = sbox_lookup(3'(b), x[47 - 6*b -: 6]);
  end

  for (genvar i = 0; i < 32; i++) begin : g_perm
    assign f[31 - i] = s_out[32 - P_TAB[i]];
  end

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES engine: one Feistel round per clock, 16 cycles per block.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_block and decrypt sampled on accept
//   in_block     64     plaintext or ciphertext, DES bit 1 = MSB
//   decrypt      1      0 = encrypt, 1 = decrypt
//   subkeys      768    subkey i at [48*i+47 : 48*i], held stable while busy
//   out_valid/out_ready output handshake
//   out_block    64     result after final permutation, held until taken
//   busy         1      high while a block is in flight or waiting to leave
module des_round_engine #(
  parameter int unsigned ROUNDS   = des_pkg::ROUNDS,
  parameter int unsigned SUBKEY_W = des_pkg::SUBKEY_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [63:0]                in_block,
  input  logic                       decrypt,
  input  logic [ROUNDS*SUBKEY_W-1:0] subkeys,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [63:0]                out_block,
  output logic                       busy
);
  import des_pkg::*;

  state_e      state_q;
  logic [31:0] l_q;
  logic [31:0] r_q;
  logic [3:0]  cnt_q;
  logic        dec_q;

  logic [SUBKEY_W-1:0] key_arr [ROUNDS];
  logic [SUBKEY_W-1:0] round_key;
  logic [31:0]         f_out;
  logic [31:0]         r_new;
  logic [63:0]         ip_out;
  logic [63:0]         fp_in;
  logic [63:0]         fp_out;

  for (genvar i = 0; i < ROUNDS; i++) begin : g_keys
    assign key_arr[i] = subkeys[i*SUBKEY_W +: SUBKEY_W];
  end

  assign round_key = key_arr[subkey_index(cnt_q, dec_q)];

  des_f_function u_f (
    .r (r_q),
    .k (round_key),
    .f (f_out)
  );

  assign r_new = l_q ^ f_out;
  // Final round output is taken with the halves un-swapped: {R16, L16}.
  assign fp_in = {r_new, r_q};

  for (genvar i = 0; i < 64; i++) begin : g_ipfp
    assign ip_out[63 - i] = in_block[64 - IP_TAB[i]];
    assign fp_out[63 - i] = fp_in[64 - FP_TAB[i]];
  end

  // Handshake flags decode from state only, so no input reaches an output combinationally.
  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      l_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      dec_q     <= 1'b0;
      out_block <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            {l_q, r_q} <= ip_out;
            dec_q      <= decrypt;
            cnt_q      <= '0;
            state_q    <= StRound;
          end
        end
        StRound: begin
          l_q <= r_q;
          r_q <= r_new;
          if (cnt_q == 4'(ROUNDS - 1)) begin
            out_block <= fp_out;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
module tb_des_round_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_block;
  logic         decrypt;
  logic [767:0] subkeys;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_block;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int acc_q[$];

  des_round_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .decrypt   (decrypt),
    .subkeys   (subkeys),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Cycle stamp of every accepted input handshake.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (rst_n && in_valid && in_ready) acc_q.push_back(cycle);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- software DES reference ----------------
  int ip_t[$] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                  64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                  61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int fp_t[$] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                  37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                  34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  int e_t[$]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                  16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int p_t[$]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                  2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int pc1_t[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                   19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                   14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int pc2_t[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                   41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int shifts[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  logic [63:0] sbox_t [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  // Generic table permutation: result is right-aligned, first table entry ends up as MSB.
  function automatic logic [63:0] perm(input logic [63:0] v, input int in_w, input int tab[$]);
    logic [63:0] o = '0;
    foreach (tab[i]) o = (o << 1) | ((v >> (in_w - tab[i])) & 64'd1);
    return o;
  endfunction

  function automatic logic [767:0] key_sched(input logic [63:0] key);
    logic [55:0]  cd;
    logic [27:0]  c;
    logic [27:0]  d;
    logic [767:0] sk = '0;
    cd = 56'(perm(key, 64, pc1_t));
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < shifts[i]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      sk[i*48 +: 48] = 48'(perm({8'h00, c, d}, 56, pc2_t));
    end
    return sk;
  endfunction

  function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s = '0;
    int six, row, col;
    x = 48'(perm({32'h0, r}, 32, e_t)) ^ k;
    for (int b = 0; b < 8; b++) begin
      six = int'((x >> (42 - 6*b)) & 48'h3f);
      row = ((six >> 4) & 2) | (six & 1);
      col = (six >> 1) & 15;
      s = (s << 4) | 32'((sbox_t[b*4 + row] >> (60 - 4*col)) & 64'hf);
    end
    return 32'(perm({32'h0, s}, 32, p_t));
  endfunction

  function automatic logic [63:0] des_model(input logic [63:0] blk, input logic [767:0] sk,
                                            input logic dec);
    logic [63:0] t;
    logic [31:0] l, r, tmp;
    int j;
    t = perm(blk, 64, ip_t);
    l = t[63:32];
    r = t[31:0];
    for (int i = 0; i < 16; i++) begin
      j = dec ? 15 - i : i;
      tmp = r;
      r = l ^ f_model(r, sk[j*48 +: 48]);
      l = tmp;
    end
    return perm({r, l}, 64, fp_t);
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic do_accept(input logic [63:0] blk, input logic d);
    int n = 0;
    in_block = blk;
    decrypt  = d;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_block = {$urandom, $urandom};
    decrypt  = 1'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_block = '0; decrypt = 1'b0; subkeys = '0;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (out_block !== 64'h0) begin bad++; $display("FAIL rst_out_block: got %h want 0", out_block); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_rst_idle: got rdy=%b busy=%b ov=%b want 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_kat_encrypt();
    int lat;
    logic [63:0] want = 64'h85E813540F0AB405;
    logic [63:0] mdl;
    subkeys = key_sched(64'h133457799BBCDFF1);
    mdl = des_model(64'h0123456789ABCDEF, subkeys, 1'b0);
    total++; if (mdl !== want) begin bad++; $display("FAIL model_kat: got %h want %h", mdl, want); end
    do_accept(64'h0123456789ABCDEF, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL enc_busy_round: got %b want 1", busy); end
    wait_out(lat);
    total++; if (lat != 16) begin bad++; $display("FAIL enc_latency: got %0d want 16", lat); end
    total++; if (out_block !== want) begin bad++; $display("FAIL enc_block: got %h want %h", out_block, want); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL enc_rdy_done: got %b want 0", in_ready); end
    take_output();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL enc_after_hs: got ov=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_kat_decrypt();
    int lat;
    subkeys = key_sched(64'h133457799BBCDFF1);
    do_accept(64'h85E813540F0AB405, 1'b1);
    wait_out(lat);
    total++; if (lat != 16) begin bad++; $display("FAIL dec_latency: got %0d want 16", lat); end
    total++;
    if (out_block !== 64'h0123456789ABCDEF) begin
      bad++; $display("FAIL dec_block: got %h want 0123456789abcdef", out_block);
    end
    take_output();
  endtask

  task automatic test_ignore_in_valid();
    int lat, extra, n0;
    n0 = acc_q.size();
    subkeys = key_sched(64'h0E329232EA6D0D73);
    do_accept(64'h8787878787878787, 1'b0);
    repeat (5) @(negedge clk);
    in_valid = 1'b1; in_block = {$urandom, $urandom}; decrypt = 1'b1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ign_rdy_round: got %b want 0", in_ready); end
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    total++; if (lat + 7 != 16) begin bad++; $display("FAIL ign_latency: got %0d want 16", lat + 7); end
    total++; if (out_block !== 64'h0) begin bad++; $display("FAIL ign_block: got %h want 0", out_block); end
    take_output();
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid === 1'b1) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL ign_extra_out: got %0d want 0", extra); end
    total++;
    if (acc_q.size() - n0 != 1) begin
      bad++; $display("FAIL ign_accepts: got %0d want 1", acc_q.size() - n0);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [63:0] blk = {$urandom, $urandom};
    logic [63:0] key = {$urandom, $urandom};
    logic [63:0] want;
    subkeys = key_sched(key);
    want = des_model(blk, subkeys, 1'b0);
    do_accept(blk, 1'b0);
    wait_out(lat);
    total++; if (lat != 16) begin bad++; $display("FAIL bp_latency: got %0d want 16", lat); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_block !== want || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_stall_%0d: got ov=%b blk=%h rdy=%b want 1 %h 0",
                 i, out_valid, out_block, in_ready, want);
      end
    end
    take_output();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release: got ov=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_single: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int lat, stale;
    logic [63:0] blk;
    logic [63:0] want;
    subkeys = key_sched(64'h133457799BBCDFF1);
    do_accept(64'h0123456789ABCDEF, 1'b0);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rmid_round: got ov=%b busy=%b rdy=%b want 0 0 1", out_valid, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL rmid_stale: got %0d want 0", stale); end
    // Abort a finished block that is still waiting in DONE.
    do_accept(64'h0123456789ABCDEF, 1'b0);
    wait_out(lat);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rmid_done: got ov=%b busy=%b want 0 0", out_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    blk = {$urandom, $urandom};
    want = des_model(blk, subkeys, 1'b1);
    do_accept(blk, 1'b1);
    wait_out(lat);
    total++; if (lat != 16) begin bad++; $display("FAIL rmid_latency: got %0d want 16", lat); end
    total++; if (out_block !== want) begin bad++; $display("FAIL rmid_block: got %h want %h", out_block, want); end
    take_output();
  endtask

  task automatic test_back_to_back();
    int lat, stall;
    logic [63:0] blk;
    logic [63:0] want;
    logic        d;
    acc_q.delete();
    for (int n = 0; n < 20; n++) begin
      subkeys = key_sched({$urandom, $urandom});
      blk = {$urandom, $urandom};
      d = 1'($urandom);
      want = des_model(blk, subkeys, d);
      out_ready = 1'($urandom);
      do_accept(blk, d);
      wait_out(lat);
      total++; if (lat != 16) begin bad++; $display("FAIL b2b_latency_%0d: got %0d want 16", n, lat); end
      total++;
      if (out_block !== want) begin
        bad++; $display("FAIL b2b_block_%0d: got %h want %h (dec=%b)", n, out_block, want, d);
      end
      if (out_ready !== 1'b1) begin
        stall = $urandom_range(0, 5);
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
      end
      @(negedge clk);
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_hs_%0d: got %b want 0", n, out_valid); end
    end
    total++; if (acc_q.size() != 20) begin bad++; $display("FAIL b2b_count: got %0d want 20", acc_q.size()); end
    for (int i = 1; i < acc_q.size(); i++) begin
      total++;
      if (acc_q[i] - acc_q[i-1] < 18) begin
        bad++; $display("FAIL b2b_gap_%0d: got %0d want >=18", i, acc_q[i] - acc_q[i-1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_kat_encrypt();
    test_kat_decrypt();
    test_ignore_in_valid();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
